// File: rtl/serial_word_rx_if.sv
// serial_word_rx_if: serial bit stream in, parallel word out with valid/ready.
// The perr wire exists only when SERIAL_RX_PARITY_EN is defined.
interface serial_word_rx_if #(
  parameter int len = 16
);
  logic           si;
  logic           en;
  logic           sync;
  logic           dready;
  logic           clr;
  logic [len-1:0] dout;
  logic           dvalid;
  logic           busy;
  logic           ovf;
`ifdef SERIAL_RX_PARITY_EN
  logic           perr;
`endif

  // Receiver side
  modport slave (
    input  si, en, sync, dready, clr,
`ifdef SERIAL_RX_PARITY_EN
    output perr,
`endif
    output dout, dvalid, busy, ovf
  );

  // Bit-stream source and word consumer side
  modport master (
    output si, en, sync, dready, clr,
`ifdef SERIAL_RX_PARITY_EN
    input  perr,
`endif
    input  dout, dvalid, busy, ovf
  );
endinterface

// File: rtl/serial_word_rx.sv
// serial_word_rx: MSB-first serial-to-parallel receiver with a registered
// valid/ready output word and a sticky overrun flag.
// Optional even-parity bit after each word: define SERIAL_RX_PARITY_EN.
//
// state | meaning
// IDLE  | waiting for en&sync (bit 0 of a frame)
// SHIFT | collecting data bits, count = bits received so far
// PAR   | all data bits in, next en bit is the parity bit (parity build only)
module serial_word_rx #(
  parameter int len = 16
) (
  input logic            clk,
  input logic            rstn,
  serial_word_rx_if.slave bus
);

  localparam int            CW       = $clog2(len + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(len - 1);

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [len-1:0] sr_q;
  logic [len-1:0] sr_d;
  logic [len-1:0] dout_q;
  logic [len-1:0] word_d;
  logic           dvalid_q;
  logic           ovf_q;
  logic           busy_q;
  logic           commit;
  logic           accept;
  logic           overrun;
`ifdef SERIAL_RX_PARITY_EN
  logic           perr_q;
  logic           perr_d;
`endif

  // Shift candidate, word completion and the commit/overrun decision.
  // A sync bit always wins over completion: the partial word is dropped.
  always_comb begin
    sr_d   = {sr_q[len-2:0], bus.si};
    word_d = sr_d;
    commit = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    perr_d = ^{sr_q, bus.si};
    if (state_q == PAR && bus.en && !bus.sync) begin
      commit = 1'b1;
      word_d = sr_q;
    end
`else
    if (state_q == SHIFT && bus.en && !bus.sync && cnt_q == CNT_LAST) begin
      commit = 1'b1;
    end
`endif
    accept  = commit && (!dvalid_q || bus.dready);
    overrun = commit && dvalid_q && !bus.dready;
  end

  // Frame FSM: shift register, bit counter and registered busy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      busy_q  <= 1'b0;
    end else if (bus.en) begin
      case (state_q)
        IDLE: begin
          if (bus.sync) begin
            sr_q    <= sr_d;
            cnt_q   <= CNT_ONE;
            state_q <= SHIFT;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          sr_q <= sr_d;
          if (bus.sync) begin
            cnt_q <= CNT_ONE;
          end else if (cnt_q == CNT_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
            cnt_q   <= cnt_q + CNT_ONE;
            state_q <= PAR;
`else
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PAR: begin
          if (bus.sync) begin
            sr_q    <= sr_d;
            cnt_q   <= CNT_ONE;
            state_q <= SHIFT;
          end else begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output holding register, handshake and sticky overrun (set beats clr).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        dout_q   <= word_d;
        dvalid_q <= 1'b1;
      end else if (dvalid_q && bus.dready) begin
        dvalid_q <= 1'b0;
      end

      if (overrun) begin
        ovf_q <= 1'b1;
      end else if (bus.clr) begin
        ovf_q <= 1'b0;
      end

`ifdef SERIAL_RX_PARITY_EN
      // perr tracks the word held in dout; a new commit overrides clr.
      if (accept) begin
        perr_q <= perr_d;
      end else if (bus.clr) begin
        perr_q <= 1'b0;
      end
`endif
    end
  end

  assign bus.dout   = dout_q;
  assign bus.dvalid = dvalid_q;
  assign bus.busy   = busy_q;
  assign bus.ovf    = ovf_q;
`ifdef SERIAL_RX_PARITY_EN
  assign bus.perr   = perr_q;
`endif

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: word-level model plus directed frames.
module tb_serial_word_rx;

  localparam int LEN = 16;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;
  logic cmp_en;

  serial_word_rx_if #(.len(LEN)) bus_if ();

  serial_word_rx #(.len(LEN)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-level model: bits are accumulated arithmetically, a word is
  // complete after LEN data bits (plus one parity bit when configured).
  int          m_nbits;
  logic        m_inframe;
  logic [15:0] m_acc;
  logic [15:0] m_dout;
  logic        m_dvalid;
  logic        m_ovf;
  logic        m_done;
`ifdef SERIAL_RX_PARITY_EN
  logic        m_perr;
  logic        m_pe;
`endif

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_nbits   = 0;
      m_inframe = 1'b0;
      m_acc     = '0;
      m_dout    = '0;
      m_dvalid  = 1'b0;
      m_ovf     = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      m_perr    = 1'b0;
      m_pe      = 1'b0;
`endif
    end else begin
      m_done = 1'b0;
      if (bus_if.en) begin
        if (bus_if.sync) begin
          m_inframe = 1'b1;
          m_nbits   = 1;
          m_acc     = {15'd0, bus_if.si};
        end else if (m_inframe) begin
          if (m_nbits < LEN) begin
            m_acc   = 16'((m_acc * 2) + {15'd0, bus_if.si});
            m_nbits = m_nbits + 1;
`ifndef SERIAL_RX_PARITY_EN
            if (m_nbits == LEN) begin
              m_done    = 1'b1;
              m_inframe = 1'b0;
            end
`endif
          end
`ifdef SERIAL_RX_PARITY_EN
          else begin
            m_done    = 1'b1;
            m_inframe = 1'b0;
            m_pe      = ^{m_acc, bus_if.si};
          end
`endif
        end
      end
      if (m_done && m_dvalid && !bus_if.dready) m_ovf = 1'b1;
      else if (bus_if.clr) m_ovf = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      if (m_done && (!m_dvalid || bus_if.dready)) m_perr = m_pe;
      else if (bus_if.clr) m_perr = 1'b0;
`endif
      if (m_done && (!m_dvalid || bus_if.dready)) begin
        m_dout   = m_acc;
        m_dvalid = 1'b1;
      end else if (m_dvalid && bus_if.dready) begin
        m_dvalid = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    if (cmp_en && rstn) begin
      chk("cyc_dout",   bus_if.dout, m_dout);
      chk("cyc_dvalid", 16'(bus_if.dvalid), 16'(m_dvalid));
      chk("cyc_ovf",    16'(bus_if.ovf), 16'(m_ovf));
      chk("cyc_busy",   16'(bus_if.busy), 16'(m_inframe));
`ifdef SERIAL_RX_PARITY_EN
      chk("cyc_perr",   16'(bus_if.perr), 16'(m_perr));
`endif
    end
  end

  task automatic send_bit(input logic b, input logic s);
    bus_if.si   = b;
    bus_if.sync = s;
    bus_if.en   = 1'b1;
    @(posedge clk); #1;
    bus_if.en   = 1'b0;
    bus_if.sync = 1'b0;
  endtask

  task automatic idle(input int n);
    bus_if.en = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // One full frame; rdy_last raises dready before the completion edge.
  task automatic send_word(input logic [15:0] w, input bit gaps, input bit rdy_last);
    for (int i = LEN - 1; i >= 0; i--) begin
`ifndef SERIAL_RX_PARITY_EN
      if (i == 0 && rdy_last) bus_if.dready = 1'b1;
`endif
      send_bit(w[i], i == LEN - 1);
      if (gaps && i != 0) idle($urandom_range(0, 2));
    end
`ifdef SERIAL_RX_PARITY_EN
    if (rdy_last) bus_if.dready = 1'b1;
    send_bit(^w, 1'b0);
`endif
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    cmp_en      = 1'b0;
    rstn        = 1'b0;
    bus_if.si     = 1'b0;
    bus_if.en     = 1'b0;
    bus_if.sync   = 1'b0;
    bus_if.dready = 1'b0;
    bus_if.clr    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout",   bus_if.dout, 16'h0000);
    chk("rst_dvalid", 16'(bus_if.dvalid), 16'h0);
    chk("rst_busy",   16'(bus_if.busy), 16'h0);
    chk("rst_ovf",    16'(bus_if.ovf), 16'h0);
    rstn   = 1'b1;
    cmp_en = 1'b1;

    // en without sync is ignored in IDLE
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    chk("nosync_busy", 16'(bus_if.busy), 16'h0);

    // Basic word
    bus_if.dready = 1'b1;
    send_word(16'hA5C3, 1'b0, 1'b0);
    chk("basic_dout",   bus_if.dout, 16'hA5C3);
    chk("basic_dvalid", 16'(bus_if.dvalid), 16'h1);
    chk("basic_ovf",    16'(bus_if.ovf), 16'h0);
    idle(1);
    chk("basic_drain",  16'(bus_if.dvalid), 16'h0);

    // Overrun, back-to-back frames
    bus_if.dready = 1'b0;
    send_word(16'h1234, 1'b0, 1'b0);
    send_word(16'hFFFF, 1'b0, 1'b0);
    chk("ovr_dout", bus_if.dout, 16'h1234);
    chk("ovr_ovf",  16'(bus_if.ovf), 16'h1);
    bus_if.clr = 1'b1;
    idle(1);
    bus_if.clr = 1'b0;
    chk("ovr_clr", 16'(bus_if.ovf), 16'h0);
    bus_if.dready = 1'b1;
    idle(1);
    chk("ovr_drain", 16'(bus_if.dvalid), 16'h0);

    // Accept and commit on the same edge
    bus_if.dready = 1'b0;
    send_word(16'h5A5A, 1'b0, 1'b0);
    send_word(16'h0F0F, 1'b0, 1'b1);
    chk("sim_dout",   bus_if.dout, 16'h0F0F);
    chk("sim_dvalid", 16'(bus_if.dvalid), 16'h1);
    chk("sim_ovf",    16'(bus_if.ovf), 16'h0);
    idle(2);

    // Resync after 5 bits, then a paused frame
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    send_word(16'h00FF, 1'b1, 1'b0);
    chk("resync_dout", bus_if.dout, 16'h00FF);
    chk("resync_ovf",  16'(bus_if.ovf), 16'h0);
    idle(2);

`ifdef SERIAL_RX_PARITY_EN
    for (int i = LEN - 1; i >= 0; i--) send_bit(((16'hFF00 >> i) & 16'h1) != 0, i == LEN - 1);
    send_bit(1'b0, 1'b0);
    chk("par_ok_dout", bus_if.dout, 16'hFF00);
    chk("par_ok_perr", 16'(bus_if.perr), 16'h0);
    idle(1);
    for (int i = LEN - 1; i >= 0; i--) send_bit(((16'hFF00 >> i) & 16'h1) != 0, i == LEN - 1);
    send_bit(1'b1, 1'b0);
    chk("par_bad_perr", 16'(bus_if.perr), 16'h1);
    idle(2);
`else
    for (int i = LEN - 1; i >= 0; i--) send_bit(((16'h8001 >> i) & 16'h1) != 0, i == LEN - 1);
    chk("bit16_dout",   bus_if.dout, 16'h8001);
    chk("bit16_dvalid", 16'(bus_if.dvalid), 16'h1);
    idle(2);
`endif

    // Reset mid-frame with a held word and a pending overrun
    bus_if.dready = 1'b0;
    send_word(16'h1111, 1'b0, 1'b0);
    send_word(16'h2222, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b0);
    chk("mid_busy", 16'(bus_if.busy), 16'h1);
    chk("mid_ovf",  16'(bus_if.ovf), 16'h1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_dout",   bus_if.dout, 16'h0000);
    chk("arst_dvalid", 16'(bus_if.dvalid), 16'h0);
    chk("arst_busy",   16'(bus_if.busy), 16'h0);
    chk("arst_ovf",    16'(bus_if.ovf), 16'h0);
    @(negedge clk); #2;
    rstn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    chk("post_rst_busy", 16'(bus_if.busy), 16'h0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial-to-parallel receiver that forms the opposite end of the team's `len`-bit serial shift-register link. It samples the serial bit stream on qualified clock edges and assembles `len`-bit words MSB-first. Each completed word is presented on a registered parallel output with a valid/ready handshake, and a sticky overrun flag is raised when a word is lost. It sits downstream of the shift register's `so` output and feeds parallel consumers (register banks, FIFOs).

## Interface
- `len`, 16, word width in bits (≥2).
- `clk`  input  1  rising-edge clock, the only clock.
- `rstn`  input  1  asynchronous active-low reset.
- `si`  input  1  serial data in; sampled only when `en`=1.
- `en`  input  1  bit strobe; each `clk` rising edge with `en`=1 consumes one bit.
- `sync`  input  1  frame start; meaningful only when `en`=1; marks the current bit as bit 0 of a new word.
- `dout`  output  `len`  received word, held stable while `dvalid`=1.
- `dvalid`  output  1  `dout` holds an unconsumed word.
- `dready`  input  1  consumer accepts; transfer when `dvalid`&`dready` at a rising edge.
- `busy`  output  1  a frame is in progress (state ≠ IDLE).
- `ovf`  output  1  sticky overrun flag.
- `clr`  input  1  synchronous clear of `ovf` (and `perr` when configured).
- `perr`  output  1  parity-error flag for the word in `dout`; exists only with `SERIAL_RX_PARITY_EN`.

## Operation
- Internals: `len`-bit shift register (`sr`), bit counter of width $clog2(`len`+1), output holding register, and an FSM with states IDLE, SHIFT and PAR (PAR only with parity).
- IDLE:
  - `en`&`sync` → `sr` = {`sr`[len-2:0], `si`}, count = 1, go to SHIFT.
  - `en` without `sync` → bit discarded, no state change.
- SHIFT, on `en`:
  - Shift `si` into the LSB and increment the count.
  - When the count reaches `len`, the word is complete: go to PAR if parity is configured, else commit and return to IDLE.
  - `en`&`sync` in SHIFT or PAR aborts the partial word (nothing committed, `ovf` unaffected) and restarts as bit 0 with count = 1.
- Bit order: the first bit received lands in `dout[len-1]`.
- Commit (same edge that samples the last bit):
  - If `dvalid`=0, or `dvalid`&`dready` at that edge, load `dout` and set `dvalid`=1.
  - If `dvalid`=1 and `dready`=0, discard the new word, keep the old `dout`, and set `ovf`=1.
- Handshake: `dvalid` clears on `dvalid`&`dready` unless a commit happens on the same edge, in which case `dvalid` stays 1 with the new data.
- `ovf`: sticky until `clr`. If `clr` and a new overrun occur on the same edge, `ovf` = 1 (set wins).
- `en`=0 cycles inside a frame are pauses: state and count are held indefinitely.
- `busy` = 1 in SHIFT and PAR.

## Timing
- Reset (async, any time, including mid-frame): state IDLE, count 0, `sr` 0, `dout` 0, `dvalid` 0, `ovf` 0, `busy` 0, `perr` 0. The partial frame is lost.
- Latency:
  - Without parity, `dout`/`dvalid` update at the edge sampling the last data bit, i.e. minimum `len` clocks after the `sync` edge, counting the `sync` edge as clock 1.
  - With parity, one extra `en` bit is needed.
- Full throughput: a new `sync` frame may start on the edge immediately after the completion edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SERIAL_RX_PARITY_EN` defined:
  - After `len` data bits the FSM enters PAR.
  - The next `en` bit is the even-parity bit. Commit occurs on that edge, and `perr` is loaded with ^{word, parity bit} alongside `dout`.
  - `perr` follows `dout`: it is not cleared by the handshake, only by a new commit, `clr` or reset.
- `SERIAL_RX_PARITY_EN` undefined: no PAR state, no `perr` port, commit on the last data bit.

## Test plan
- Reset: assert `rstn`=0 mid-frame (count 7) → all outputs 0 immediately. After release, `en` pulses without `sync` are ignored (`busy`=0).
- Basic word: `sync` + 16 bits of 0xA5C3 MSB-first at consecutive `en` edges, `dready`=1 → `dout`=0xA5C3, `dvalid`=1 for one cycle, `ovf`=0.
- Overrun: 0x1234 then 0xFFFF back-to-back with `dready`=0 → `dout` stays 0x1234, `ovf`=1. Then `clr` → `ovf`=0, and `dready`=1 → `dvalid`=0.
- Simultaneous: `dready` asserted on the completion edge of a second word → `dout` switches to the new word, `dvalid` stays 1, `ovf`=0.
- Resync and pauses: `sync` reasserted after 5 bits, followed by 0x00FF with random `en`=0 gaps → `dout`=0x00FF, no overrun.
- Parity (macro on): 0xFF00 with parity bit 0 → `perr`=0. Same word with parity bit 1 → `perr`=1. Without the macro, the next word commits on bit 16.
